// File: rtl/btb_pkg.sv
// btb_pkg: shared types and geometry for the BTB update path.
//   SETS/IDX_W      : BTB geometry (2-way, 8 sets)
//   TAG_W/TGT_W     : stored tag and target widths
//   WAY1/WAY2       : way encoding used on the LRU bit
//   btb_upd_t       : one queued EX-stage update request
//   ctrl_state_t    : update controller FSM states
package btb_pkg;
  localparam int SETS  = 8;
  localparam int IDX_W = 3;
  localparam int TAG_W = 27;
  localparam int TGT_W = 32;

  localparam logic WAY1 = 1'b0;
  localparam logic WAY2 = 1'b1;

  typedef struct packed {
    logic [IDX_W-1:0] index;
    logic [TAG_W-1:0] tag;
    logic [TGT_W-1:0] target;
    logic             hit1;
    logic             hit2;
  } btb_upd_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } ctrl_state_t;
endpackage

// File: rtl/btb_upd_fifo.sv
// btb_upd_fifo: synchronous FIFO of btb_upd_t update requests.
//   clk, rst   : clock, synchronous active-high reset
//   clr        : synchronous clear (drops all entries, wins over push/pop)
//   push/din   : enqueue
//   pop        : dequeue head (caller guarantees non-empty)
//   head       : current head entry (valid when count != 0)
//   count      : occupancy 0..DEPTH
module btb_upd_fifo
  import btb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  btb_upd_t         din,
  input  logic             pop,
  output btb_upd_t         head,
  output logic [CNT_W-1:0] count
);
  localparam int PW = $clog2(DEPTH);

  btb_upd_t        mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;

  // Storage needs no reset; occupancy decides what is meaningful.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{(CNT_W-1){1'b0}}, push} - {{(CNT_W-1){1'b0}}, pop};
    end
  end

  assign head = mem[rd_ptr];
endmodule

// File: rtl/btb_update_ctrl.sv
// btb_update_ctrl: owns the single BTB/LRU write port.
//   upd_*          : EX-stage resolved-branch update request (valid/ready)
//   if_touch       : IF stage owns the LRU port this cycle (stalls updates)
//   flush_req      : request a full invalidate sweep; flush_busy while sweeping
//   lru_rd_index   : LRU read index (= FIFO head set), lru_rd_bit returns it
//   lru_wr_*       : LRU table write (bit 0 = way1 MRU, 1 = way2 MRU)
//   btb_wr_*       : BTB way array write (mask bit0 = way1, bit1 = way2)
//   q_count        : update FIFO occupancy
module btb_update_ctrl
  import btb_pkg::*;
#(
  parameter int QDEPTH = 4,
  parameter int CNT_W  = $clog2(QDEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             upd_valid,
  output logic             upd_ready,
  input  logic [IDX_W-1:0] upd_index,
  input  logic [TAG_W-1:0] upd_tag,
  input  logic [TGT_W-1:0] upd_target,
  input  logic             upd_hit1,
  input  logic             upd_hit2,
  input  logic             if_touch,
  input  logic             flush_req,
  output logic             flush_busy,
  output logic [IDX_W-1:0] lru_rd_index,
  input  logic             lru_rd_bit,
  output logic             lru_wr_en,
  output logic [IDX_W-1:0] lru_wr_index,
  output logic             lru_wr_bit,
  output logic             btb_wr_en,
  output logic [1:0]       btb_wr_mask,
  output logic [IDX_W-1:0] btb_wr_index,
  output logic [TAG_W-1:0] btb_wr_tag,
  output logic [TGT_W-1:0] btb_wr_target,
  output logic             btb_wr_valid,
  output logic [CNT_W-1:0] q_count
);
  localparam logic [CNT_W-1:0] Q_FULL   = CNT_W'(QDEPTH);
  localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(SETS - 1);

  ctrl_state_t      state;
  logic [IDX_W-1:0] flush_idx;
  btb_upd_t         head, din;
  logic             push, pop, clr, empty, upd_wr, victim;

  assign din = '{index: upd_index, tag: upd_tag, target: upd_target,
                 hit1: upd_hit1, hit2: upd_hit2};

  assign upd_ready = (q_count < Q_FULL) && (state == IDLE) && !flush_req;
  assign push      = upd_valid && upd_ready;
  // A flush request drops the queue, so no update write goes out alongside it.
  assign clr       = (state == IDLE) && flush_req;
  assign empty     = (q_count == '0);
  assign upd_wr    = (state == IDLE) && !empty && !if_touch && !flush_req;
  assign pop       = upd_wr;

  btb_upd_fifo #(.DEPTH(QDEPTH), .CNT_W(CNT_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .head  (head),
    .count (q_count)
  );

  assign lru_rd_index = head.index;
  assign flush_busy   = (state == FLUSH);

  // LRU bit names the MRU way, so the victim is the other one.
  assign victim = ~lru_rd_bit;

  always_comb begin
    btb_wr_en     = 1'b0;
    btb_wr_mask   = 2'b00;
    btb_wr_index  = '0;
    btb_wr_tag    = '0;
    btb_wr_target = '0;
    btb_wr_valid  = 1'b0;
    lru_wr_bit    = 1'b0;
    if (state == FLUSH) begin
      btb_wr_en    = 1'b1;
      btb_wr_mask  = 2'b11;
      btb_wr_index = flush_idx;
    end else if (upd_wr) begin
      btb_wr_en     = 1'b1;
      btb_wr_index  = head.index;
      btb_wr_tag    = head.tag;
      btb_wr_target = head.target;
      btb_wr_valid  = 1'b1;
      if (head.hit1) begin
        btb_wr_mask = 2'b01;
        lru_wr_bit  = WAY1;
      end else if (head.hit2) begin
        btb_wr_mask = 2'b10;
        lru_wr_bit  = WAY2;
      end else begin
        btb_wr_mask = (victim == WAY1) ? 2'b01 : 2'b10;
        lru_wr_bit  = victim;
      end
    end
  end

  assign lru_wr_en    = btb_wr_en;
  assign lru_wr_index = btb_wr_index;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      flush_idx <= '0;
    end else begin
      case (state)
        IDLE: if (flush_req) state <= FLUSH;
        FLUSH: begin
          if (flush_idx == LAST_SET) begin
            flush_idx <= '0;
            state     <= IDLE;
          end else begin
            flush_idx <= flush_idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_btb_update_ctrl.sv
module tb_btb_update_ctrl;
  import btb_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             upd_valid, upd_ready;
  logic [IDX_W-1:0] upd_index;
  logic [TAG_W-1:0] upd_tag;
  logic [TGT_W-1:0] upd_target;
  logic             upd_hit1, upd_hit2, if_touch, flush_req, flush_busy;
  logic [IDX_W-1:0] lru_rd_index, lru_wr_index, btb_wr_index;
  logic             lru_rd_bit, lru_wr_en, lru_wr_bit, btb_wr_en, btb_wr_valid;
  logic [1:0]       btb_wr_mask;
  logic [TAG_W-1:0] btb_wr_tag;
  logic [TGT_W-1:0] btb_wr_target;
  logic [2:0]       q_count;

  int total = 0;
  int bad   = 0;

  // Bench-side LRU table memory
  logic lru_tab [SETS];
  assign lru_rd_bit = lru_tab[lru_rd_index];
  always @(posedge clk) begin
    if (rst) for (int i = 0; i < SETS; i++) lru_tab[i] <= 1'b0;
    else if (lru_wr_en) lru_tab[lru_wr_index] <= lru_wr_bit;
  end

  always #5 clk = ~clk;

  btb_update_ctrl dut (
    .clk(clk), .rst(rst),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_index(upd_index),
    .upd_tag(upd_tag), .upd_target(upd_target), .upd_hit1(upd_hit1),
    .upd_hit2(upd_hit2), .if_touch(if_touch), .flush_req(flush_req),
    .flush_busy(flush_busy), .lru_rd_index(lru_rd_index), .lru_rd_bit(lru_rd_bit),
    .lru_wr_en(lru_wr_en), .lru_wr_index(lru_wr_index), .lru_wr_bit(lru_wr_bit),
    .btb_wr_en(btb_wr_en), .btb_wr_mask(btb_wr_mask), .btb_wr_index(btb_wr_index),
    .btb_wr_tag(btb_wr_tag), .btb_wr_target(btb_wr_target),
    .btb_wr_valid(btb_wr_valid), .q_count(q_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic v, input int idx, input int tg, input int tgt,
                     input logic h1, input logic h2);
    upd_valid  = v;
    upd_index  = IDX_W'(idx);
    upd_tag    = TAG_W'(tg);
    upd_target = TGT_W'(tgt);
    upd_hit1   = h1;
    upd_hit2   = h2;
  endtask

  task automatic chk_wr(input string tag, input int idx, input int mask,
                        input int tg, input int tgt, input logic vld, input logic lbit);
    chk({tag, "_en"},    btb_wr_en, 1);
    chk({tag, "_lru_en"}, lru_wr_en, 1);
    chk({tag, "_idx"},   btb_wr_index, 64'(idx));
    chk({tag, "_lidx"},  lru_wr_index, 64'(idx));
    chk({tag, "_mask"},  btb_wr_mask, 64'(mask));
    chk({tag, "_tag"},   btb_wr_tag, 64'(tg));
    chk({tag, "_tgt"},   btb_wr_target, 64'(tgt));
    chk({tag, "_vld"},   btb_wr_valid, 64'(vld));
    chk({tag, "_lbit"},  lru_wr_bit, 64'(lbit));
  endtask

  initial begin
    rst = 1'b1; if_touch = 1'b0; flush_req = 1'b0;
    req(0, 0, 0, 0, 0, 0);
    tick(); tick();
    // reset state
    chk("rst_qcount", q_count, 0);
    chk("rst_wr_en", btb_wr_en, 0);
    chk("rst_lru_en", lru_wr_en, 0);
    chk("rst_busy", flush_busy, 0);
    chk("rst_tag", btb_wr_tag, 0);
    chk("rst_tgt", btb_wr_target, 0);
    rst = 1'b0;
    #1;
    chk("rst_ready", upd_ready, 1);

    // single miss at set 3, LRU=0 -> victim way2
    req(1, 3, 'h111, 'h4000, 0, 0);
    #1;
    chk("m1_no_wr_yet", btb_wr_en, 0);
    tick();
    req(0, 0, 0, 0, 0, 0);
    #1;
    chk("m1_q", q_count, 1);
    chk_wr("m1", 3, 2'b10, 'h111, 'h4000, 1, 1);
    tick();
    chk("m1_q_after", q_count, 0);
    chk("m1_idle", btb_wr_en, 0);

    // back-to-back misses at set 5 fill opposite ways
    req(1, 5, 'h0A, 'h5000, 0, 0);
    tick();
    req(1, 5, 'h0B, 'h5004, 0, 0);
    #1;
    chk_wr("m2a", 5, 2'b10, 'h0A, 'h5000, 1, 1);
    tick();
    req(0, 0, 0, 0, 0, 0);
    #1;
    chk_wr("m2b", 5, 2'b01, 'h0B, 'h5004, 1, 0);
    tick();
    chk("m2_q", q_count, 0);

    // hit2 stalled by if_touch for 3 cycles
    req(1, 2, 'h22, 'h1230, 0, 1);
    if_touch = 1'b1;
    tick();
    req(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("h2_stall_en", btb_wr_en, 0);
      chk("h2_stall_lru", lru_wr_en, 0);
      chk("h2_stall_q", q_count, 1);
      tick();
    end
    if_touch = 1'b0;
    #1;
    chk_wr("h2", 2, 2'b10, 'h22, 'h1230, 1, 1);
    tick();

    // fill FIFO under if_touch; 5th request is refused
    if_touch = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req(1, i, 'h100 + i, 'h8000 + 4 * i, 1, i == 1);
      #1;
      chk("fill_ready", upd_ready, (i < 4) ? 1 : 0);
      if (i < 4) tick();
    end
    chk("fill_q", q_count, 4);
    req(0, 0, 0, 0, 0, 0);
    if_touch = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk_wr("drain", i, 2'b01, 'h100 + i, 'h8000 + 4 * i, 1, 0);
      tick();
    end
    chk("drain_q", q_count, 0);

    // flush with 2 queued updates; if_touch held high throughout
    if_touch = 1'b1;
    req(1, 6, 'h66, 'h6000, 0, 0);
    tick();
    req(1, 7, 'h77, 'h7000, 0, 0);
    tick();
    req(0, 0, 0, 0, 0, 0);
    chk("fl_pre_q", q_count, 2);
    flush_req = 1'b1;
    #1;
    chk("fl_req_ready", upd_ready, 0);
    tick();
    for (int k = 0; k < SETS; k++) begin
      if (k == 2) flush_req = 1'b0;
      #1;
      chk("fl_busy", flush_busy, 1);
      chk("fl_q", q_count, 0);
      chk("fl_ready", upd_ready, 0);
      chk_wr("fl", k, 2'b11, 0, 0, 0, 0);
      tick();
    end
    chk("fl_done_busy", flush_busy, 0);
    chk("fl_done_ready", upd_ready, 1);
    chk("fl_done_en", btb_wr_en, 0);
    if_touch = 1'b0;

    // reset in the 4th flush cycle
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    tick(); tick(); tick();
    #1;
    chk("rf_idx_before", btb_wr_index, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rf_busy", flush_busy, 0);
    chk("rf_en", btb_wr_en, 0);
    chk("rf_lru_en", lru_wr_en, 0);
    chk("rf_q", q_count, 0);
    chk("rf_ready", upd_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/btb_update_ctrl.md
Name: btb_update_ctrl

Overview:
Sequences all EX-stage writes into the 2-way, 8-set branch target buffer and its per-set LRU table. It buffers resolved-branch update requests in a small FIFO and arbitrates the single BTB/LRU write port against IF-stage LRU touches. On a miss it selects the victim way from the LRU bit. It also runs a set-by-set invalidate sweep on flush. It sits between the EX stage and the BTB way arrays plus LRU table.

Parameters:
SETS, 8, number of BTB sets
IDX_W, 3, set index width (log2 SETS)
TAG_W, 27, stored tag width
TGT_W, 32, branch target width
QDEPTH, 4, update FIFO depth (power of two)

Ports:
clk  in  1  clock
rst  in  1  reset
upd_valid  in  1  EX update request valid
upd_ready  out  1  request accepted when valid&ready
upd_index  in  IDX_W  set index of resolved branch
upd_tag  in  TAG_W  branch tag
upd_target  in  TGT_W  resolved target
upd_hit1  in  1  IF lookup hit way1
upd_hit2  in  1  IF lookup hit way2
if_touch  in  1  IF stage is using the LRU write port this cycle
flush_req  in  1  request full BTB invalidate
flush_busy  out  1  sweep in progress
lru_rd_index  out  IDX_W  LRU table read index (FIFO head index)
lru_rd_bit  in  1  combinational LRU bit for lru_rd_index
lru_wr_en  out  1  LRU write strobe
lru_wr_index  out  IDX_W  LRU write set
lru_wr_bit  out  1  0 = way1 most recently used, 1 = way2 most recently used
btb_wr_en  out  1  BTB write strobe
btb_wr_mask  out  2  bit0 = way1, bit1 = way2
btb_wr_index  out  IDX_W  BTB write set
btb_wr_tag  out  TAG_W  tag written
btb_wr_target  out  TGT_W  target written
btb_wr_valid  out  1  valid bit written
q_count  out  $clog2(QDEPTH)+1  FIFO occupancy

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset state: FSM IDLE; FIFO empty (q_count=0); flush index=0. All write strobes are 0; flush_busy=0; write data outputs are 0. upd_ready=1 in the first cycle after reset.
- Reset mid-sweep or with the FIFO non-empty: all pending work is discarded; there is no partial write.
- States:
  - IDLE: drain the FIFO and accept requests.
  - FLUSH: sweep sets 0..SETS-1.
- upd_ready = (q_count < QDEPTH) && state == IDLE && !flush_req. There is no full-FIFO bypass.
- Enqueue and dequeue in the same cycle: q_count is unchanged, and ordering is strict FIFO.
- Latency: a request accepted at edge t reaches the FIFO head. Its write is issued in cycle t+1 at the earliest.
- lru_rd_index always equals the head index.
- Write issue: the head is written when the FIFO is non-empty, state is IDLE and if_touch=0. If if_touch=1, the head stalls with no write that cycle. A write pops the head.
- Hit on way1 (upd_hit1=1, including when upd_hit2=1): mask=01, target updated, tag rewritten, valid=1, lru_wr_bit=0.
- Hit on way2 only: mask=10, same fields, lru_wr_bit=1.
- Miss (neither hit bit set):
  - Victim way = ~lru_rd_bit; lru_rd_bit=0 selects way2.
  - mask = one-hot of the victim way.
  - Write tag, target and valid=1.
  - lru_wr_bit = victim way (0 = way1, 1 = way2).
- lru_wr_en = btb_wr_en, with lru_wr_index = btb_wr_index, on every update write.
- Back-to-back misses to the same set: the second miss reads the LRU bit updated by the first, so the two misses fill opposite ways.
- Flush:
  - flush_req seen in IDLE moves the FSM to FLUSH on the next edge and clears the FIFO; queued updates are dropped.
  - In FLUSH, one set is written per cycle at index 0..SETS-1: mask=11, valid=0, tag=0, target=0, lru_wr_bit=0.
  - if_touch is ignored during FLUSH; the flush owns the port.
  - flush_busy=1 throughout FLUSH. Return to IDLE follows the set SETS-1 write.
  - flush_req during FLUSH is ignored.
- The flush index wraps from SETS-1 to 0 on exit.

Decomposition:
- Package btb_pkg holds:
  - SETS, IDX_W, TAG_W, TGT_W.
  - Way constants WAY1=1'b0 and WAY2=1'b1.
  - Packed struct btb_upd_t {index, tag, target, hit1, hit2}.
  - Enum ctrl_state_t {IDLE, FLUSH}.
- Sub-module btb_upd_fifo: a parameterised synchronous FIFO of btb_upd_t with count, push/pop and synchronous active-high reset.

Test Plan:
- Reset, then one miss at index 3 with lru_rd_bit=0: btb_wr_en rises the cycle after acceptance with mask=10, valid=1, lru_wr_bit=1, q_count returns to 0.
- Two misses to index 5 back-to-back, LRU table starting at 0: writes use mask 10 then 01; lru_wr_bit is 1 then 0.
- Hit2 update with upd_target=0x0000_1230 while if_touch is held high for 3 cycles: no write for 3 cycles, then mask=10, target=0x1230, lru_wr_bit=1.
- Push 5 requests with if_touch held high: upd_ready drops after the 4th and q_count=4. Release if_touch: 4 writes follow in order.
- flush_req with 2 queued updates: q_count goes to 0 and flush_busy=1 for 8 cycles. btb_wr_index steps 0..7 with mask=11 and valid=0, and if_touch is ignored. upd_ready returns to 1 afterwards.
- rst asserted in the 4th flush cycle: the next cycle shows IDLE, no write strobes, flush_busy=0, q_count=0.
